// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types: transfer/response/size/burst encodings and the
// memory-slave FSM state.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    // WAIT: OKAY data phase stalled; ERR1/ERR2: two-cycle ERROR response.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_e;

endpackage

// File: rtl/ahb_mem_slave_param_if.sv
// AHB-Lite slave-side bus bundle; the decoder/master drives it through the
// master modport, the memory slave consumes it through the slave modport.
interface ahb_mem_slave_param_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              hsel;
    logic              hreadyin;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;

    modport master (
        output hsel, hreadyin, hwrite, htrans, hsize, hburst, haddr, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  hsel, hreadyin, hwrite, htrans, hsize, hburst, haddr, hwdata,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/ahb_byte_strobe.sv
// Byte-lane enable decode from transfer size and low address bits.
// A lane is enabled when it agrees with the address on every bit above the
// size, i.e. it falls inside the naturally aligned 2**hsize byte block.
module ahb_byte_strobe
    import ahb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]                   hsize,
    input  logic [$clog2(DATA_W/8)-1:0]  addr_lo,
    output logic [DATA_W/8-1:0]          byte_en
);
    localparam int LW = $clog2(DATA_W/8);

    for (genvar gi = 0; gi < DATA_W/8; gi++) begin : g_lane
        localparam logic [LW-1:0] LANE = LW'(gi);
        // Sizes at or above the bus width shift everything out: all lanes on.
        assign byte_en[gi] = (((LANE ^ addr_lo) >> hsize) == '0);
    end
endmodule

// File: rtl/ahb_mem_slave_param.sv
// Parametrised AHB-Lite memory slave with configurable wait states,
// byte/halfword writes and a two-cycle ERROR response for illegal transfers.
module ahb_mem_slave_param
    import ahb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  hreset,
    ahb_mem_slave_param_if.slave  bus
);
    localparam int NB = DATA_W / 8;
    localparam int LW = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam int OW = IW + LW;
    localparam logic [ADDR_W:0] REGION_BYTES = (ADDR_W+1)'(DEPTH * NB);
    localparam logic [2:0]      MAX_SIZE     = 3'(LW);
    localparam logic [3:0]      WAIT_LOAD    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slv_state_e        state_reg, state_next;
    logic [3:0]        wait_cnt_reg, wait_cnt_next;
    logic              dp_valid_reg;
    logic              dp_write_reg;
    logic [2:0]        dp_size_reg;
    logic [OW-1:0]     dp_off_reg;

    logic              hready_int;
    logic              accept;
    logic              legal;
    logic [ADDR_W:0]   addr_off;
    logic              complete;
    logic [IW-1:0]     idx;
    logic [NB-1:0]     byte_en;
    logic              unused_bits;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    // A borrow out of the subtraction (address below base) lands in the top
    // bit, so one unsigned compare covers both ends of the region.
    assign addr_off = {1'b0, bus.haddr} - {1'b0, BASE_ADDR};
    assign legal    = (addr_off < REGION_BYTES)
                    && ((bus.haddr & ~({ADDR_W{1'b1}} << bus.hsize)) == '0)
                    && (bus.hsize <= MAX_SIZE);

    assign hready_int = (state_reg == ST_IDLE) || (state_reg == ST_ERR2);
    assign accept     = bus.hsel && bus.hreadyin && hready_int && bus.htrans[1];

    // An OKAY data phase finishes in the first IDLE-state cycle after accept.
    assign complete = dp_valid_reg && (state_reg == ST_IDLE);
    assign idx      = dp_off_reg[OW-1:LW];

    assign bus.hready = hready_int;
    assign bus.hresp  = (state_reg == ST_ERR1) || (state_reg == ST_ERR2);
    assign bus.hrdata = (complete && !dp_write_reg) ? mem[idx] : '0;

    assign unused_bits = ^{bus.hburst, bus.htrans[0], addr_off[ADDR_W:OW]};

    ahb_byte_strobe #(.DATA_W(DATA_W)) u_strobe (
        .hsize   (dp_size_reg),
        .addr_lo (dp_off_reg[LW-1:0]),
        .byte_en (byte_en)
    );

    // State and wait counter registers.
    always_ff @(posedge clk or posedge hreset) begin
        if (hreset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Next state: stall for OKAY wait states, two cycles for ERROR.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_IDLE, ST_ERR2: begin
                state_next = ST_IDLE;
                if (accept) begin
                    if (!legal) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            default: state_next = ST_IDLE;
        endcase
    end

    // Data-phase registers load whenever the bus moves on (hready high);
    // reset drops any pending transfer so a stalled write never commits.
    always_ff @(posedge clk or posedge hreset) begin
        if (hreset) begin
            dp_valid_reg <= 1'b0;
            dp_write_reg <= 1'b0;
            dp_size_reg  <= '0;
            dp_off_reg   <= '0;
        end else if (hready_int) begin
            dp_valid_reg <= accept && legal;
            if (accept) begin
                dp_write_reg <= bus.hwrite;
                dp_size_reg  <= bus.hsize;
                dp_off_reg   <= addr_off[OW-1:0];
            end
        end
    end

    // Byte-masked write commit at the edge that ends the data phase.
    always_ff @(posedge clk) begin
        if (complete && dp_write_reg) begin
            for (int b = 0; b < NB; b++) begin
                if (byte_en[b]) begin
                    mem[idx][b*8 +: 8] <= bus.hwdata[b*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ahb_mem_slave_param.sv
// Bench for ahb_mem_slave_param: three instances (0 wait states at base 0,
// 2 wait states at base 0x2000, 3 wait states at base 0) behind a one-hot
// select, a pipelined master engine and a byte-array reference model.
module tb_ahb_mem_slave_param;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic        has_exp;
        logic        exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int dsel  = 0;

    logic        m_hsel = 1'b0, m_hwrite = 1'b0;
    logic [1:0]  m_htrans = 2'b00;
    logic [2:0]  m_hsize = 3'd0, m_hburst = 3'd0;
    logic [31:0] m_haddr = '0, m_hwdata = '0;

    logic        rd_hready [3];
    logic        rd_hresp  [3];
    logic [31:0] rd_hrdata [3];
    logic        bus_hready, bus_hresp;
    logic [31:0] bus_hrdata;

    ahb_mem_slave_param_if #(.ADDR_W(32), .DATA_W(32)) bus_if [3] ();

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int          WS   = (gi == 0) ? 0 : (gi == 1) ? 2 : 3;
        localparam logic [31:0] BASE = (gi == 1) ? 32'h0000_2000 : 32'h0;
        assign bus_if[gi].hsel     = m_hsel && (dsel == gi);
        assign bus_if[gi].hreadyin = bus_hready;
        assign bus_if[gi].hwrite   = m_hwrite;
        assign bus_if[gi].htrans   = m_htrans;
        assign bus_if[gi].hsize    = m_hsize;
        assign bus_if[gi].hburst   = m_hburst;
        assign bus_if[gi].haddr    = m_haddr;
        assign bus_if[gi].hwdata   = m_hwdata;
        assign rd_hready[gi] = bus_if[gi].hready;
        assign rd_hresp[gi]  = bus_if[gi].hresp;
        assign rd_hrdata[gi] = bus_if[gi].hrdata;
        ahb_mem_slave_param #(
            .ADDR_W(32), .DATA_W(32), .DEPTH(256),
            .BASE_ADDR(BASE), .WAIT_STATES(WS)
        ) u_dut (
            .clk    (clk),
            .hreset (rst),
            .bus    (bus_if[gi])
        );
    end

    // Bus-level response mux: the selected slave drives hready/hresp/hrdata.
    always_comb begin
        bus_hready = rd_hready[0];
        bus_hresp  = rd_hresp[0];
        bus_hrdata = rd_hrdata[0];
        if (dsel == 1) begin
            bus_hready = rd_hready[1]; bus_hresp = rd_hresp[1]; bus_hrdata = rd_hrdata[1];
        end else if (dsel == 2) begin
            bus_hready = rd_hready[2]; bus_hresp = rd_hresp[2]; bus_hrdata = rd_hrdata[2];
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] mdl [3][1024];
    vec_t q[$];

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 2 : 3;
    endfunction

    function automatic longint base_of(input int d);
        return (d == 1) ? 64'h2000 : 64'h0;
    endfunction

    function automatic bit mdl_legal(input int d, input logic [31:0] a, input logic [2:0] sz);
        longint off;
        longint nbytes;
        off    = longint'(a) - base_of(d);
        nbytes = longint'(1) << sz;
        return (off >= 0) && (off < 1024) && ((longint'(a) % nbytes) == 0) && (nbytes <= 4);
    endfunction

    function automatic logic [31:0] mdl_read(input int d, input logic [31:0] a);
        int w;
        logic [31:0] r;
        w = int'(longint'(a) - base_of(d)) / 4 * 4;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = mdl[d][w + k];
        return r;
    endfunction

    task automatic mdl_write(input int d, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] dat);
        int off;
        off = int'(longint'(a) - base_of(d));
        for (int b = 0; b < (1 << sz); b++) begin
            mdl[d][off + b] = dat[8*((off + b) % 4) +: 8];
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut=%0d actual=%h required=%h", nm, dsel, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [1:0] tr, input logic w, input logic [2:0] sz,
                                input logic [31:0] a, input logic [31:0] dat,
                                input logic he, input logic er, input logic [31:0] erd);
        vec_t v;
        v.sel = s; v.trans = tr; v.wr = w; v.size = sz; v.addr = a; v.data = dat;
        v.has_exp = he; v.exp_resp = er; v.exp_rdata = erd;
        return v;
    endfunction

    task automatic finish_xfer(input vec_t t, input bit real_x, input bit legal, input int waits, input int exp_w);
        logic [31:0] exp_rd;
        bit          exp_resp;
        exp_rd   = (real_x && legal && !t.wr) ? mdl_read(dsel, t.addr) : 32'h0;
        exp_resp = real_x && !legal;
        $display("xfer dut=%0d sel=%0d trans=%0d wr=%0d size=%0d addr=%h resp=%0d rdata=%h waits=%0d",
                 dsel, t.sel, t.trans, t.wr, t.size, t.addr, bus_hresp, bus_hrdata, waits);
        chk("waits", 64'(waits), 64'(exp_w));
        chk("hresp", 64'(bus_hresp), 64'(exp_resp));
        chk("hrdata", 64'(bus_hrdata), 64'(exp_rd));
        if (t.has_exp) begin
            chk("tbl_hresp", 64'(bus_hresp), 64'(t.exp_resp));
            chk("tbl_hrdata", 64'(bus_hrdata), 64'(t.exp_rdata));
        end
        if (real_x && legal && t.wr) mdl_write(dsel, t.addr, t.size, t.data);
    endtask

    // Pipelined master: presents the next address phase every cycle the bus
    // is ready, so back-to-back transfers overlap their data phases.
    task automatic run_queue();
        int   n, ai, waits, exp_w;
        bit   dp_v, dp_real, dp_legal;
        vec_t dp;
        n = q.size(); ai = 0; waits = 0; exp_w = 0;
        dp_v = 0; dp_real = 0; dp_legal = 0;
        dp = mk(0, 2'b00, 0, 3'd0, 32'h0, 32'h0, 0, 0, 32'h0);
        while (ai < n || dp_v) begin
            if (ai < n) begin
                m_hsel = q[ai].sel; m_htrans = q[ai].trans; m_hwrite = q[ai].wr;
                m_hsize = q[ai].size; m_haddr = q[ai].addr;
                m_hburst = (q[ai].trans == 2'b11) ? 3'd3 : 3'd0;
            end else begin
                m_hsel = 1'b0; m_htrans = 2'b00;
            end
            // Garbage on hwdata until the cycle the write is due to complete.
            if (dp_v && dp.wr && waits >= exp_w) m_hwdata = dp.data;
            else m_hwdata = $urandom;
            @(negedge clk);
            if (bus_hready) begin
                if (dp_v) finish_xfer(dp, dp_real, dp_legal, waits, exp_w);
                if (ai < n) begin
                    dp = q[ai]; ai++; dp_v = 1; waits = 0;
                    dp_real  = dp.sel && dp.trans[1];
                    dp_legal = dp_real && mdl_legal(dsel, dp.addr, dp.size);
                    exp_w    = !dp_real ? 0 : (dp_legal ? ws_of(dsel) : 1);
                end else begin
                    dp_v = 0;
                end
            end else begin
                waits++;
                if (!dp_v) begin
                    chk("hready_no_xfer", 64'(bus_hready), 64'd1);
                end else begin
                    chk("stall_hresp", 64'(bus_hresp), 64'(dp_real && !dp_legal));
                    chk("stall_hrdata", 64'(bus_hrdata), 64'd0);
                end
                if (waits > 40) begin
                    chk("stall_limit", 64'(waits), 64'(exp_w));
                    dp_v = 0; ai = n;
                end
            end
            @(posedge clk); #1;
        end
        q.delete();
    endtask

    task automatic gen_random(input int count);
        vec_t        v;
        int          r, sz;
        logic [31:0] off, mask;
        for (int i = 0; i < count; i++) begin
            r  = $urandom_range(0, 19);
            sz = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 2) : 3;
            mask = (32'd1 << sz) - 32'd1;
            v = mk(1, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10, $urandom_range(0, 1) != 0,
                   3'(sz), 32'h0, $urandom, 0, 0, 32'h0);
            if (r == 0) v.sel = 0;
            else if (r == 1) v.trans = 2'b00;
            else if (r == 2) v.trans = 2'b01;
            r = $urandom_range(0, 9);
            if (r <= 6)      off = 32'($urandom_range(0, 63)) & ~mask;
            else if (r == 7) off = 32'($urandom_range(0, 63));
            else if (r == 8) off = 32'(1016 + $urandom_range(0, 15)) & ~mask;
            else             off = $urandom;
            v.addr = (r == 9) ? off : off + 32'(base_of(dsel));
            q.push_back(v);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog dut=%0d actual=timeout required=finish", dsel);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [24];
        for (int d = 0; d < 3; d++)
            for (int a = 0; a < 1024; a++) mdl[d][a] = 8'h00;

        tbl[0]  = mk(1, 2'b10, 1, 3'd2, 32'h10,  32'hDEADBEEF, 0, 0, 32'h0);
        tbl[1]  = mk(1, 2'b10, 0, 3'd2, 32'h10,  32'h0,        1, 0, 32'hDEADBEEF);
        tbl[2]  = mk(1, 2'b10, 1, 3'd2, 32'h20,  32'h11223344, 0, 0, 32'h0);
        tbl[3]  = mk(1, 2'b10, 1, 3'd0, 32'h21,  32'h5555AA55, 0, 0, 32'h0);
        tbl[4]  = mk(1, 2'b10, 0, 3'd2, 32'h20,  32'h0,        1, 0, 32'h1122AA44);
        tbl[5]  = mk(1, 2'b10, 1, 3'd1, 32'h22,  32'hBEEF7777, 0, 0, 32'h0);
        tbl[6]  = mk(1, 2'b10, 0, 3'd2, 32'h20,  32'h0,        1, 0, 32'hBEEFAA44);
        tbl[7]  = mk(1, 2'b10, 1, 3'd2, 32'h40,  32'd1,        0, 0, 32'h0);
        tbl[8]  = mk(1, 2'b11, 1, 3'd2, 32'h44,  32'd2,        0, 0, 32'h0);
        tbl[9]  = mk(1, 2'b11, 1, 3'd2, 32'h48,  32'd3,        0, 0, 32'h0);
        tbl[10] = mk(1, 2'b11, 1, 3'd2, 32'h4C,  32'd4,        0, 0, 32'h0);
        tbl[11] = mk(1, 2'b10, 0, 3'd2, 32'h40,  32'h0,        1, 0, 32'd1);
        tbl[12] = mk(1, 2'b11, 0, 3'd2, 32'h44,  32'h0,        1, 0, 32'd2);
        tbl[13] = mk(1, 2'b11, 0, 3'd2, 32'h48,  32'h0,        1, 0, 32'd3);
        tbl[14] = mk(1, 2'b11, 0, 3'd2, 32'h4C,  32'h0,        1, 0, 32'd4);
        tbl[15] = mk(1, 2'b10, 1, 3'd2, 32'h400, 32'hFFFFFFFF, 1, 1, 32'h0);
        tbl[16] = mk(1, 2'b00, 0, 3'd0, 32'h0,   32'h0,        1, 0, 32'h0);
        tbl[17] = mk(1, 2'b10, 1, 3'd2, 32'h2,   32'hFFFFFFFF, 1, 1, 32'h0);
        tbl[18] = mk(1, 2'b10, 0, 3'd2, 32'h0,   32'h0,        1, 0, 32'h0);
        tbl[19] = mk(1, 2'b10, 1, 3'd1, 32'h3,   32'hFFFFFFFF, 1, 1, 32'h0);
        tbl[20] = mk(1, 2'b10, 0, 3'd3, 32'h8,   32'h0,        1, 1, 32'h0);
        tbl[21] = mk(1, 2'b10, 0, 3'd2, 32'h3FC, 32'h0,        1, 0, 32'h0);
        tbl[22] = mk(0, 2'b10, 1, 3'd2, 32'h0,   32'hFFFFFFFF, 0, 0, 32'h0);
        tbl[23] = mk(1, 2'b10, 0, 3'd2, 32'h0,   32'h0,        1, 0, 32'h0);

        // Reset state of every instance.
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            dsel = i;
            chk("rst_hready", 64'(rd_hready[i]), 64'd1);
            chk("rst_hresp",  64'(rd_hresp[i]),  64'd0);
            chk("rst_hrdata", 64'(rd_hrdata[i]), 64'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table on the zero-wait instance, all back-to-back.
        dsel = 0;
        for (int i = 0; i < 24; i++) q.push_back(tbl[i]);
        run_queue();

        // Two wait states, offset base: read, below-base write, readback.
        dsel = 1;
        q.push_back(mk(1, 2'b10, 0, 3'd2, 32'h2000, 32'h0,        1, 0, 32'h0));
        q.push_back(mk(1, 2'b10, 1, 3'd2, 32'h1FFC, 32'hFFFFFFFF, 1, 1, 32'h0));
        q.push_back(mk(1, 2'b10, 1, 3'd2, 32'h23FC, 32'hA5A5A5A5, 0, 0, 32'h0));
        q.push_back(mk(1, 2'b10, 0, 3'd2, 32'h23FC, 32'h0,        1, 0, 32'hA5A5A5A5));
        run_queue();

        // Reset in the middle of a stalled write.
        dsel = 2;
        q.push_back(mk(1, 2'b10, 1, 3'd2, 32'h8, 32'hCAFEF00D, 0, 0, 32'h0));
        run_queue();
        m_hsel = 1'b1; m_htrans = 2'b10; m_hwrite = 1'b1; m_hsize = 3'd2;
        m_haddr = 32'h8; m_hwdata = 32'h12345678;
        @(posedge clk); #1;
        m_hsel = 1'b0; m_htrans = 2'b00;
        @(negedge clk);
        chk("t6_in_wait_hready", 64'(bus_hready), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_hready", 64'(bus_hready), 64'd1);
        chk("t6_rst_hresp",  64'(bus_hresp),  64'd0);
        chk("t6_rst_hrdata", 64'(bus_hrdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        q.push_back(mk(1, 2'b10, 0, 3'd2, 32'h8, 32'h0,        1, 0, 32'hCAFEF00D));
        q.push_back(mk(1, 2'b10, 1, 3'd2, 32'h8, 32'h0BADCAFE, 0, 0, 32'h0));
        q.push_back(mk(1, 2'b10, 0, 3'd2, 32'h8, 32'h0,        1, 0, 32'h0BADCAFE));
        run_queue();

        // Randomised traffic on each instance against the byte model.
        for (int d = 0; d < 3; d++) begin
            dsel = d;
            for (int c = 0; c < 3; c++) begin
                gen_random(40);
                run_queue();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
